// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of the shared UART TX: grants one requester per frame, holds tx_en for the
// TX enable window, acks on tx_done or flags a timeout. Grant registered 1 edge after req in IDLE; req held until ack.
module uart_tx_scheduler #(
   parameter int N_REQ   = 4,
   parameter int EN_HOLD = 12,
   parameter int TIMEOUT = 32,
   parameter int FLUSH   = 22
) (
   input  logic                 clk_9k6hz,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [16*N_REQ-1:0]  req_data,
   input  logic                 err_clr,
   input  logic                 tx_done,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     ack,
   output logic                 tx_en,
   output logic [15:0]          tx_data,
   output logic                 busy,
   output logic                 timeout_err
);
   localparam int CNT_MAX = (TIMEOUT > FLUSH) ? TIMEOUT : FLUSH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] C_SAT        = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] C_FLUSH_LAST = CNT_W'(FLUSH - 2);
   localparam logic [CNT_W-1:0] C_EN_LAST    = CNT_W'(EN_HOLD - 1);
   localparam logic [CNT_W-1:0] C_TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] C_PTR_LAST   = PTR_W'(N_REQ - 1);

   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SEND, ST_WAIT, ST_GAP} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   r_ack;
   logic               r_tx_en;
   logic [15:0]        r_tx_data;
   logic               r_busy;
   logic               r_timeout_err;

   logic               w_found;
   logic [PTR_W-1:0]   w_winner;
   logic [N_REQ-1:0]   w_onehot;
   logic [15:0]        w_word;
   int                 w_idx;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [PTR_W-1:0]   w_next_ptr;
   logic               w_timeout;

   // Scan starts at rr_ptr so the previous winner is considered last.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_onehot = '0;
      w_word   = '0;
      w_idx    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = int'(r_rr_ptr) + i;
         if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
         if (!w_found && req[w_idx]) begin
            w_found          = 1'b1;
            w_winner         = PTR_W'(w_idx);
            w_onehot         = '0;
            w_onehot[w_idx]  = 1'b1;
            w_word           = req_data[16*w_idx +: 16];
         end
      end
   end

   assign w_cnt_inc  = (r_cnt == C_SAT) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_next_ptr = (w_winner == C_PTR_LAST) ? '0 : w_winner + PTR_W'(1);
   assign w_timeout  = (r_state == ST_WAIT) && !tx_done && (r_cnt == C_TO_LAST);

   always_ff @(posedge clk_9k6hz or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_INIT;
         r_cnt         <= '0;
         r_rr_ptr      <= '0;
         r_grant       <= '0;
         r_ack         <= '0;
         r_tx_en       <= 1'b0;
         r_tx_data     <= '0;
         r_busy        <= 1'b1;
         r_timeout_err <= 1'b0;
      end else begin
         r_ack <= '0;
         case (r_state)
            ST_INIT: begin
               r_cnt <= w_cnt_inc;
               if (r_cnt == C_FLUSH_LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (w_found) begin
                  r_grant   <= w_onehot;
                  r_tx_data <= w_word;
                  r_tx_en   <= 1'b1;
                  r_cnt     <= '0;
                  r_rr_ptr  <= w_next_ptr;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               r_cnt <= w_cnt_inc;
               if (r_cnt == C_EN_LAST) begin
                  r_tx_en <= 1'b0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (tx_done) begin
                  r_ack   <= r_grant;
                  r_grant <= '0;
                  r_state <= ST_GAP;
               end else if (w_timeout) begin
                  r_grant <= '0;
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_INIT;
         endcase
         // A timeout on the same edge as err_clr leaves the flag set.
         if (w_timeout)    r_timeout_err <= 1'b1;
         else if (err_clr) r_timeout_err <= 1'b0;
      end
   end

   assign grant       = r_grant;
   assign ack         = r_ack;
   assign tx_en       = r_tx_en;
   assign tx_data     = r_tx_data;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level checker with a round-robin reference model,
// an arbitration vector table and hand sequences for timeout, reset and stray tx_done.
module tb_uart_tx_scheduler;
   logic        clk_9k6hz = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic        err_clr;
   logic        tx_done;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic        tx_en;
   logic [15:0] tx_data;
   logic        busy;
   logic        timeout_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t_g = 0;
   int t_prev = 0;
   bit exp_te = 1'b0;

   uart_tx_scheduler #(.N_REQ(4), .EN_HOLD(12), .TIMEOUT(32), .FLUSH(22)) dut (
      .clk_9k6hz(clk_9k6hz), .rst_n(rst_n), .req(req), .req_data(req_data),
      .err_clr(err_clr), .tx_done(tx_done), .grant(grant), .ack(ack),
      .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk_9k6hz = ~clk_9k6hz;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_9k6hz);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk_9k6hz);
      rst_n = 1'b0; req = '0; tx_done = 1'b0; err_clr = 1'b0;
      #1;
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_ack", 64'(ack), 64'h0);
      chk("rst_tx_en", 64'(tx_en), 64'h0);
      chk("rst_tx_data", 64'(tx_data), 64'h0);
      chk("rst_busy", 64'(busy), 64'h1);
      chk("rst_timeout_err", 64'(timeout_err), 64'h0);
      @(negedge clk_9k6hz);
      rst_n = 1'b1;
      cyc = 0;
      exp_te = 1'b0;
   endtask

   // Round robin as a rotation: look at req starting from bit p, take the lowest set bit.
   function automatic int rr_pick(input logic [3:0] r, input int p);
      logic [7:0] dbl;
      logic [3:0] rot;
      dbl = {r, r};
      rot = dbl[p +: 4];
      for (int i = 0; i < 4; i++) if (rot[i]) return (p + i) % 4;
      return -1;
   endfunction

   // One whole frame as the TX sees it: grant, 12-sample enable, done raised after e+21
   // (when tx_ok), ack at e+22, GAP, back to IDLE; or timeout at e+32.
   task automatic frame(input logic [3:0] r, input logic [63:0] d, input logic [3:0] exp_g,
                        input bit tx_ok, input bit clr_hold, input bit drop, input int stray_k);
      logic [15:0] exp_w;
      int idx;
      int n;
      int done_k;
      int kmax;
      idx = 0;
      for (int i = 0; i < 4; i++) if (exp_g[i]) idx = i;
      exp_w = d[16*idx +: 16];
      done_k = tx_ok ? 22 : 32;
      kmax = done_k + 1;
      req = r; req_data = d; err_clr = clr_hold;
      n = 0;
      while (grant == 4'b0 && n < 60) begin
         tick();
         n++;
      end
      if (grant == 4'b0) begin
         chk("grant_wait", 64'(grant), 64'(exp_g));
         err_clr = 1'b0;
         return;
      end
      t_g = cyc;
      chk("grant", 64'(grant), 64'(exp_g));
      chk("tx_data", 64'(tx_data), 64'(exp_w));
      for (int k = 0; k <= kmax; k++) begin
         if (k > 0) tick();
         if (k == 2 && drop) req = r & ~exp_g;
         if (k == stray_k) tx_done = 1'b1;
         if (k == stray_k + 1) tx_done = 1'b0;
         if (tx_ok && k == 21) tx_done = 1'b1;
         if (k == 22) tx_done = 1'b0;
         if (!tx_ok && k == 32) exp_te = 1'b1;
         else if (clr_hold) exp_te = 1'b0;
         chk("tx_en_window", 64'(tx_en), (k < 12) ? 64'h1 : 64'h0);
         chk("grant_hold", 64'(grant), (k < done_k) ? 64'(exp_g) : 64'h0);
         chk("ack", 64'(ack), (tx_ok && k == 22) ? 64'(exp_g) : 64'h0);
         chk("busy", 64'(busy), (k < kmax) ? 64'h1 : 64'h0);
         chk("timeout_err", 64'(timeout_err), 64'(exp_te));
         if (k <= done_k) chk("tx_data_hold", 64'(tx_data), 64'(exp_w));
      end
      err_clr = 1'b0;
   endtask

   typedef struct {
      logic [3:0] r;
      logic [3:0] g;
   } vec_t;
   vec_t tbl[12];

   logic [3:0]  pend;
   logic [3:0]  eg;
   logic [63:0] dw;
   int          ptr_m;
   int          w;
   int          n;

   initial begin
      tbl[0]  = '{4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0010};
      tbl[2]  = '{4'b1111, 4'b0100};
      tbl[3]  = '{4'b1111, 4'b1000};
      tbl[4]  = '{4'b1111, 4'b0001};
      tbl[5]  = '{4'b0010, 4'b0010};
      tbl[6]  = '{4'b0011, 4'b0001};
      tbl[7]  = '{4'b0010, 4'b0010};
      tbl[8]  = '{4'b1001, 4'b1000};
      tbl[9]  = '{4'b0110, 4'b0010};
      tbl[10] = '{4'b0101, 4'b0100};
      tbl[11] = '{4'b0001, 4'b0001};

      req = '0; req_data = '0; err_clr = 1'b0; tx_done = 1'b0;

      // First frame after reset, with tx_done chatter during the flush.
      do_reset();
      tick(); tx_done = 1'b1; tick(); tick(); tx_done = 1'b0;
      chk("init_busy", 64'(busy), 64'h1);
      chk("init_tx_en", 64'(tx_en), 64'h0);
      frame(4'b0001, {48'h0, 16'hA55A}, 4'b0001, 1'b1, 1'b0, 1'b0, -1);
      chk("first_grant_edge", 64'(t_g), 64'd22);
      chk("first_byte", 64'(tx_data[7:0]), 64'h5A);
      req = '0;

      do_reset();
      for (int i = 0; i < 12; i++) begin
         dw = {16'h4000 + 16'(i), 16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i)};
         frame(tbl[i].r, dw, tbl[i].g, 1'b1, 1'b0, 1'b0, -1);
         if (i == 0) chk("table_first_edge", 64'(t_g), 64'd22);
         else        chk("grant_spacing", 64'(t_g - t_prev), 64'd24);
         t_prev = t_g;
      end
      req = '0;

      // Timeout, sticky flag, clear, then timeout with err_clr held on the same edge.
      tick(); tick();
      frame(4'b0100, 64'h0123_4567_89AB_CDEF, 4'b0100, 1'b0, 1'b0, 1'b0, -1);
      req = '0;
      tick(); tick(); tick();
      chk("timeout_sticky", 64'(timeout_err), 64'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_te = 1'b0;
      chk("timeout_cleared", 64'(timeout_err), 64'h0);
      frame(4'b0100, 64'hFEDC_BA98_7654_3210, 4'b0100, 1'b0, 1'b1, 1'b0, -1);
      req = '0;

      // Stray tx_done while IDLE must not produce an ack.
      tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      chk("stray_idle_ack", 64'(ack), 64'h0);
      chk("stray_idle_busy", 64'(busy), 64'h0);
      frame(4'b1000, 64'hBEEF_0000_0000_0000, 4'b1000, 1'b1, 1'b0, 1'b0, -1);
      req = '0;

      // Random traffic against the round-robin model.
      do_reset();
      ptr_m = 0;
      pend = '0;
      for (int f = 0; f < 30; f++) begin
         pend = pend | 4'($urandom_range(0, 15));
         if (pend == 4'b0) pend = 4'b0001 << $urandom_range(0, 3);
         w = rr_pick(pend, ptr_m);
         eg = 4'b0001 << w;
         dw = {$urandom, $urandom};
         frame(pend, dw, eg, 1'b1, 1'b0, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : -1);
         pend = pend & ~eg;
         ptr_m = (w + 1) % 4;
      end
      req = '0;

      // Asynchronous reset in the middle of a frame.
      tick();
      req = 4'b0010; req_data = 64'h0000_0000_5555_0000;
      n = 0;
      while (grant == 4'b0 && n < 60) begin
         tick();
         n++;
      end
      chk("mid_grant", 64'(grant), 64'h2);
      tick(); tick(); tick(); tick();
      @(posedge clk_9k6hz);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_en", 64'(tx_en), 64'h0);
      chk("mid_rst_grant", 64'(grant), 64'h0);
      chk("mid_rst_busy", 64'(busy), 64'h1);
      @(negedge clk_9k6hz);
      rst_n = 1'b1;
      cyc = 0;
      exp_te = 1'b0;
      frame(4'b0010, 64'h0000_0000_6666_0000, 4'b0010, 1'b1, 1'b0, 1'b0, -1);
      chk("post_rst_grant_edge", 64'(t_g), 64'd22);
      req = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
